// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the LFSR round-robin scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        DELIVER = 2'd2
    } state_t;

    localparam logic [7:0] INIT_STATE_DEFAULT = 8'b1001_0001;
    localparam logic [7:0] TAPS_DEFAULT       = 8'b1111_0011;

    // rr_pick works on a fixed-width request vector; callers zero-pad.
    localparam int RR_MAX_REQ = 16;
    localparam int RR_IDX_W   = 4;

    // First requester found searching upward from ptr+1, wrapping at num_req.
    function automatic logic [RR_IDX_W-1:0] rr_pick(
        input logic [RR_MAX_REQ-1:0] req,
        input logic [RR_IDX_W-1:0]   ptr,
        input int                    num_req
    );
        logic [RR_IDX_W-1:0] win;
        logic [RR_IDX_W-1:0] idx_v;
        logic                found;
        int                  idx;
        win   = '0;
        found = 1'b0;
        for (int i = 1; i <= num_req; i++) begin
            idx   = (int'(ptr) + i) % num_req;
            idx_v = idx[RR_IDX_W-1:0];
            if (!found && req[idx_v]) begin
                found = 1'b1;
                win   = idx_v;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// Galois LFSR with load and step enables; a zero load value is replaced by Initial_State.
// Latency: load/step take effect on the next rising edge.
// Backpressure: none, the state only moves when load or step is asserted.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int               Length           = 8,
    parameter logic [Length-1:0] Initial_State    = INIT_STATE_DEFAULT,
    parameter logic [Length-1:0] Tap_Coefficients = TAPS_DEFAULT
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              load,
    input  logic [Length-1:0] load_value,
    input  logic              step,
    output logic [Length-1:0] state
);

    // Stage k of the [1:Length] numbering lives at vector bit Length-k.
    logic [Length-1:0] state_q;
    logic [Length-1:0] state_d;
    logic [Length-1:0] stepped;
    logic              fb;

    always_comb begin
        fb      = state_q[0];
        stepped = {fb, state_q[Length-1:1] ^ (Tap_Coefficients[Length-2:0] & {(Length-1){fb}})};
        state_d = state_q;
        if (load) begin
            state_d = (load_value == '0) ? Initial_State : load_value;
        end else if (step) begin
            state_d = stepped;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= Initial_State;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/lfsr_rr_scheduler.sv
// Round-robin shares one LFSR between NumReq requesters; Length fresh steps per grant.
// Latency: Req sampled at edge t -> Valid/Gnt in the cycle after edge t+Length+1.
// Backpressure: Req is a level held until Gnt; inputs are ignored while Busy.
module lfsr_rr_scheduler
    import lfsr_pkg::*;
#(
    parameter int                Length           = 8,
    parameter int                NumReq           = 4,
    parameter logic [Length-1:0] Initial_State    = INIT_STATE_DEFAULT,
    parameter logic [Length-1:0] Tap_Coefficients = TAPS_DEFAULT
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Seed_Load,
    input  logic [Length-1:0] Seed,
    input  logic [NumReq-1:0] Req,
    output logic [NumReq-1:0] Gnt,
    output logic [Length-1:0] Y,
    output logic              Valid,
    output logic              Busy
);

    localparam int PtrW = $clog2(NumReq);
    localparam int CntW = $clog2(Length + 1);

    state_t            st_q, st_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [PtrW-1:0]   win_q, win_d;
    logic [PtrW-1:0]   ptr_q, ptr_d;
    logic [Length-1:0] y_q, y_d;
    logic [NumReq-1:0] gnt_q, gnt_d;
    logic              vld_q, vld_d;

    logic                  lfsr_load;
    logic                  lfsr_step;
    logic [Length-1:0]     lfsr_state;
    logic [RR_MAX_REQ-1:0] req_ext;
    logic [RR_IDX_W-1:0]   pick;

    lfsr_core #(
        .Length           (Length),
        .Initial_State    (Initial_State),
        .Tap_Coefficients (Tap_Coefficients)
    ) u_core (
        .Clock      (Clock),
        .Reset      (Reset),
        .load       (lfsr_load),
        .load_value (Seed),
        .step       (lfsr_step),
        .state      (lfsr_state)
    );

    always_comb begin
        req_ext              = '0;
        req_ext[NumReq-1:0]  = Req;
        pick                 = rr_pick(req_ext, RR_IDX_W'(ptr_q), NumReq);
    end

    always_comb begin
        st_d      = st_q;
        cnt_d     = cnt_q;
        win_d     = win_q;
        ptr_d     = ptr_q;
        y_d       = y_q;
        gnt_d     = '0;
        vld_d     = 1'b0;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        case (st_q)
            IDLE: begin
                if (Seed_Load) begin
                    lfsr_load = 1'b1;
                end else if (|Req) begin
                    win_d = PtrW'(pick);
                    cnt_d = CntW'(Length);
                    st_d  = SHIFT;
                end
            end
            SHIFT: begin
                lfsr_step = 1'b1;
                cnt_d     = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    st_d = DELIVER;
                end
            end
            DELIVER: begin
                // Outputs register here, so Valid shows in the following (IDLE) cycle.
                y_d          = lfsr_state;
                gnt_d[win_q] = 1'b1;
                vld_d        = 1'b1;
                ptr_d        = win_q;
                st_d         = IDLE;
            end
            default: begin
                st_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            st_q  <= IDLE;
            cnt_q <= '0;
            win_q <= '0;
            ptr_q <= PtrW'(NumReq - 1);
            y_q   <= '0;
            gnt_q <= '0;
            vld_q <= 1'b0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            win_q <= win_d;
            ptr_q <= ptr_d;
            y_q   <= y_d;
            gnt_q <= gnt_d;
            vld_q <= vld_d;
        end
    end

    assign Gnt   = gnt_q;
    assign Y     = y_q;
    assign Valid = vld_q;
    assign Busy  = (st_q != IDLE);

endmodule

// File: tb/tb_lfsr_rr_scheduler.sv
// Scoreboard bench for lfsr_rr_scheduler at default parameters, 20ns clock.
module tb_lfsr_rr_scheduler;

    logic       Clock;
    logic       Reset;
    logic       Seed_Load;
    logic [7:0] Seed;
    logic [3:0] Req;
    logic [3:0] Gnt;
    logic [7:0] Y;
    logic       Valid;
    logic       Busy;

    typedef struct packed {
        logic [3:0] gnt;
        logic [7:0] y;
    } exp_t;

    exp_t       sb_q[$];
    int         err_cnt = 0;
    int         chk_cnt = 0;
    logic [7:0] init_state = 8'b1001_0001;
    logic [7:0] taps       = 8'b1111_0011;
    logic [7:0] mlfsr;
    int         mptr;
    int         c;

    lfsr_rr_scheduler u_dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Seed_Load (Seed_Load),
        .Seed      (Seed),
        .Req       (Req),
        .Gnt       (Gnt),
        .Y         (Y),
        .Valid     (Valid),
        .Busy      (Busy)
    );

    initial Clock = 1'b0;
    always #10 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Galois step; vector bit 7 is stage 1, bit 0 is stage 8.
    function automatic logic [7:0] model_step(input logic [7:0] s);
        logic fb;
        fb = s[0];
        return {fb, s[7:1] ^ (taps[6:0] & {7{fb}})};
    endfunction

    function automatic int model_pick(input logic [3:0] req, input int ptr);
        for (int i = 1; i <= 4; i++) begin
            int idx;
            idx = (ptr + i) % 4;
            if (((req >> idx) & 4'd1) != 4'd0) return idx;
        end
        return ptr;
    endfunction

    task automatic push_grants(input logic [3:0] req, input int n);
        exp_t e;
        int   w;
        for (int g = 0; g < n; g++) begin
            w = model_pick(req, mptr);
            for (int s = 0; s < 8; s++) mlfsr = model_step(mlfsr);
            e.gnt = 4'b0001 << w;
            e.y   = mlfsr;
            sb_q.push_back(e);
            mptr = w;
        end
    endtask

    task automatic wait_valid(input int budget, output int n);
        n = 0;
        do begin
            @(negedge Clock);
            n++;
        end while (!Valid && n < budget);
        if (!Valid) chk("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_held(input logic [3:0] req, input int n, input string tag);
        int cyc;
        push_grants(req, n);
        Req = req;
        for (int g = 0; g < n; g++) begin
            wait_valid(30, cyc);
            if (g > 0) chk(tag, cyc, 32'd10);
        end
        Req = 4'b0000;
    endtask

    task automatic model_reset();
        mlfsr = init_state;
        mptr  = 3;
        sb_q.delete();
    endtask

    // Output monitor: every Valid pulse must match the next scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clock);
            if (Valid) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("gnt", 32'(Gnt), 32'(e.gnt));
                    chk("y", 32'(Y), 32'(e.y));
                end
            end else begin
                chk("gnt_without_valid", 32'(Gnt), 32'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        Reset = 1'b1; Seed_Load = 1'b0; Seed = 8'h00; Req = 4'b0000;
        model_reset();
        repeat (2) @(negedge Clock);
        chk("rst_y", 32'(Y), 32'd0);
        chk("rst_valid", 32'(Valid), 32'd0);
        chk("rst_gnt", 32'(Gnt), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        Reset = 1'b0;

        // Single requester: Busy from the sampling edge, Valid 9 clocks later.
        Req = 4'b0100;
        push_grants(4'b0100, 1);
        @(negedge Clock);
        chk("t2_busy", 32'(Busy), 32'd1);
        wait_valid(30, c);
        chk("t2_latency", c, 32'd9);
        Req = 4'b0000;

        // Reset in the middle of SHIFT aborts the grant.
        @(negedge Clock);
        Req = 4'b0001;
        repeat (4) @(negedge Clock);
        #3 Reset = 1'b1;
        #1;
        chk("t1_busy", 32'(Busy), 32'd0);
        chk("t1_valid", 32'(Valid), 32'd0);
        chk("t1_gnt", 32'(Gnt), 32'd0);
        model_reset();
        @(negedge Clock);
        chk("t1_y", 32'(Y), 32'd0);
        Reset = 1'b0;
        push_grants(4'b0001, 1);
        wait_valid(30, c);
        chk("t1_latency", c, 32'd10);
        Req = 4'b0000;

        // All requesters: full rotation with 10-clock spacing.
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        model_reset();
        run_held(4'b1111, 5, "t3_spacing");

        // Sparse requesters: only slots 1 and 3 alternate.
        run_held(4'b1010, 4, "t4_spacing");

        // Zero seed beats a simultaneous request and falls back to Initial_State.
        Seed_Load = 1'b1; Seed = 8'h00; Req = 4'b0001;
        @(negedge Clock);
        chk("t5_seed_wins", 32'(Busy), 32'd0);
        Seed_Load = 1'b0;
        mlfsr = init_state;
        push_grants(4'b0001, 1);
        @(negedge Clock);
        chk("t5_grant_next", 32'(Busy), 32'd1);
        wait_valid(30, c);
        Req = 4'b0000;

        // Nonzero seed is loaded verbatim.
        Seed_Load = 1'b1; Seed = 8'h5A;
        @(negedge Clock);
        Seed_Load = 1'b0;
        mlfsr = 8'h5A;
        Req = 4'b1000;
        push_grants(4'b1000, 1);
        wait_valid(30, c);
        Req = 4'b0000;

        // Req dropped and Seed_Load pulsed mid-SHIFT: grant still delivered, seed ignored.
        Req = 4'b0010;
        push_grants(4'b0010, 1);
        @(negedge Clock);
        repeat (3) @(negedge Clock);
        Req = 4'b0000; Seed_Load = 1'b1; Seed = 8'hFF;
        @(negedge Clock);
        Seed_Load = 1'b0;
        wait_valid(30, c);
        chk("t6_latency", c, 32'd5);
        run_held(4'b0100, 1, "t6_follow");

        repeat (2) @(negedge Clock);
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
